bsg_manycore_return_tracker: RTL

Parametrised outstanding-request tracker for a manycore endpoint. Assigns a tracking id (carried in the packet reg_id field) to every outgoing remote request, records the return packet type and load_info each request expects, and matches incoming return packets against that record. It produces a byte-selected integer, float or ifetch writeback, frees the id, flags protocol errors, and drives an empty signal for fences. It sits between the core's remote-request issue logic and the endpoint's return-packet FIFO.

---
 rtl/bsg_manycore_return_tracker.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bsg_manycore_return_tracker.sv
// rtl/bsg_manycore_return_tracker.sv - outstanding remote-request tracker
// Hands out reg_ids, matches return packets against them, and produces byte-selected writebacks.
module bsg_manycore_return_tracker #(
  parameter int reg_id_width_p = 5,
  parameter int max_out_p      = 32,
  parameter int data_width_p   = 32
) (
  input  logic                      clk_i,
  input  logic                      reset_i,

  input  logic                      alloc_v_i,
  input  logic [3:0]                alloc_op_i,
  input  logic [6:0]                alloc_load_info_i,
  output logic                      alloc_ready_o,
  output logic [reg_id_width_p-1:0] alloc_id_o,

  input  logic                      ret_v_i,
  output logic                      ret_ready_o,
  input  logic [1:0]                ret_type_i,
  input  logic [reg_id_width_p-1:0] ret_id_i,
  input  logic [data_width_p-1:0]   ret_data_i,

  output logic                      wb_v_o,
  input  logic                      wb_yumi_i,
  output logic [1:0]                wb_type_o,
  output logic [reg_id_width_p-1:0] wb_id_o,
  output logic [data_width_p-1:0]   wb_data_o,

  output logic [reg_id_width_p:0]   out_count_o,
  output logic                      empty_o,
  output logic                      err_v_o,
  output logic [1:0]                err_code_o
);

  localparam int depth_lp       = 1 << reg_id_width_p;
  localparam int count_width_lp = reg_id_width_p + 1;

  localparam logic [1:0] e_return_credit   = 2'd0;
  localparam logic [1:0] e_return_int_wb   = 2'd1;
  localparam logic [1:0] e_return_float_wb = 2'd2;
  localparam logic [1:0] e_return_ifetch   = 2'd3;

  localparam logic [3:0] e_remote_load     = 4'd0;
  localparam logic [3:0] e_remote_store    = 4'd1;
  localparam logic [3:0] e_remote_sw       = 4'd2;
  localparam logic [3:0] e_cache_op        = 4'd3;
  localparam logic [3:0] e_last_legal_op   = 4'd12;

  localparam logic [1:0] err_unknown_id    = 2'd1;
  localparam logic [1:0] err_type_mismatch = 2'd2;
  localparam logic [1:0] err_illegal_op    = 2'd3;

  typedef struct packed {
    logic       float_wb;
    logic       icache_fetch;
    logic       is_unsigned_op;
    logic       is_byte_op;
    logic       is_hex_op;
    logic [1:0] part_sel;
  } load_info_s;

  // Only the extraction controls are kept per entry; the routing bits are folded into exp_type.
  typedef struct packed {
    logic       is_unsigned_op;
    logic       is_byte_op;
    logic       is_hex_op;
    logic [1:0] part_sel;
  } sel_info_s;

  logic [depth_lp-1:0]       valid_r, valid_n;
  logic [1:0]                exp_type_r [depth_lp];
  sel_info_s                 sel_info_r [depth_lp];

  logic                      free_found;
  logic [count_width_lp-1:0] out_count;

  load_info_s                alloc_info;
  logic [1:0]                alloc_exp_type;
  sel_info_s                 alloc_sel_info;
  logic                      alloc_hs, alloc_illegal, alloc_do;

  logic                      ret_accept, ret_hit, ret_match, ret_free, wb_load;
  logic [1:0]                ret_exp_type;
  sel_info_s                 ret_sel_info;
  logic [7:0]                sel_byte;
  logic [15:0]               sel_half;
  logic [data_width_p-1:0]   wb_data_n;

  logic                      wb_v_r;
  logic [1:0]                wb_type_r;
  logic [reg_id_width_p-1:0] wb_id_r;
  logic [data_width_p-1:0]   wb_data_r;

  logic                      err_v_r;
  logic [1:0]                err_code_r;
  logic                      err_hit;
  logic [1:0]                err_code_n;

  // Descending scan so the last hit is the lowest free index.
  always_comb begin
    free_found = 1'b0;
    alloc_id_o = '0;
    for (int i = depth_lp - 1; i >= 0; i--) begin
      if (!valid_r[i]) begin
        free_found = 1'b1;
        alloc_id_o = reg_id_width_p'(i);
      end
    end
  end

  always_comb begin
    out_count = '0;
    for (int i = 0; i < depth_lp; i++) begin
      out_count = out_count + count_width_lp'(valid_r[i]);
    end
  end

  assign out_count_o   = out_count;
  assign empty_o       = (out_count == '0);
  assign alloc_ready_o = free_found & (out_count < count_width_lp'(max_out_p));

  assign alloc_info    = load_info_s'(alloc_load_info_i);
  assign alloc_hs      = alloc_v_i & alloc_ready_o;
  assign alloc_illegal = alloc_hs & (alloc_op_i > e_last_legal_op);
  assign alloc_do      = alloc_hs & ~alloc_illegal;

  always_comb begin
    alloc_exp_type = e_return_credit;
    alloc_sel_info = '{is_unsigned_op: alloc_info.is_unsigned_op,
                       is_byte_op:     alloc_info.is_byte_op,
                       is_hex_op:      alloc_info.is_hex_op,
                       part_sel:       alloc_info.part_sel};
    case (alloc_op_i)
      e_remote_load: begin
        if (alloc_info.icache_fetch)  alloc_exp_type = e_return_ifetch;
        else if (alloc_info.float_wb) alloc_exp_type = e_return_float_wb;
        else                          alloc_exp_type = e_return_int_wb;
      end
      e_remote_store, e_remote_sw, e_cache_op: begin
        alloc_exp_type = e_return_credit;
      end
      default: begin
        // Atomics always return the full word.
        alloc_exp_type = e_return_int_wb;
        alloc_sel_info = '0;
      end
    endcase
  end

  assign ret_ready_o  = ~wb_v_r | wb_yumi_i;
  assign ret_accept   = ret_v_i & ret_ready_o;
  assign ret_hit      = valid_r[ret_id_i];
  assign ret_exp_type = exp_type_r[ret_id_i];
  assign ret_sel_info = sel_info_r[ret_id_i];
  assign ret_free     = ret_accept & ret_hit;
  assign ret_match    = ret_free & (ret_type_i == ret_exp_type);
  assign wb_load      = ret_match & (ret_type_i != e_return_credit);

  always_comb begin
    case (ret_sel_info.part_sel)
      2'd0:    sel_byte = ret_data_i[7:0];
      2'd1:    sel_byte = ret_data_i[15:8];
      2'd2:    sel_byte = ret_data_i[23:16];
      default: sel_byte = ret_data_i[31:24];
    endcase
    sel_half = ret_sel_info.part_sel[1] ? ret_data_i[31:16] : ret_data_i[15:0];

    wb_data_n = ret_data_i;
    if (ret_type_i == e_return_int_wb) begin
      if (ret_sel_info.is_byte_op) begin
        wb_data_n = ret_sel_info.is_unsigned_op
                  ? {{(data_width_p-8){1'b0}}, sel_byte}
                  : {{(data_width_p-8){sel_byte[7]}}, sel_byte};
      end else if (ret_sel_info.is_hex_op) begin
        wb_data_n = ret_sel_info.is_unsigned_op
                  ? {{(data_width_p-16){1'b0}}, sel_half}
                  : {{(data_width_p-16){sel_half[15]}}, sel_half};
      end
    end
  end

  // Return-side errors take precedence over an illegal op in the same cycle.
  always_comb begin
    err_hit    = 1'b0;
    err_code_n = '0;
    if (ret_accept & ~ret_hit) begin
      err_hit    = 1'b1;
      err_code_n = err_unknown_id;
    end else if (ret_free & ~ret_match) begin
      err_hit    = 1'b1;
      err_code_n = err_type_mismatch;
    end else if (alloc_illegal) begin
      err_hit    = 1'b1;
      err_code_n = err_illegal_op;
    end
  end

  always_comb begin
    valid_n = valid_r;
    if (ret_free) valid_n[ret_id_i]   = 1'b0;
    if (alloc_do) valid_n[alloc_id_o] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_r    <= '0;
      wb_v_r     <= 1'b0;
      wb_type_r  <= '0;
      wb_id_r    <= '0;
      wb_data_r  <= '0;
      err_v_r    <= 1'b0;
      err_code_r <= '0;
    end else begin
      valid_r <= valid_n;
      if (wb_load) begin
        wb_v_r    <= 1'b1;
        wb_type_r <= ret_type_i;
        wb_id_r   <= ret_id_i;
        wb_data_r <= wb_data_n;
      end else if (wb_yumi_i) begin
        wb_v_r <= 1'b0;
      end
      if (err_hit & ~err_v_r) begin
        err_v_r    <= 1'b1;
        err_code_r <= err_code_n;
      end
    end
  end

  // Entry payload is qualified by valid_r, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (alloc_do) begin
      exp_type_r[alloc_id_o] <= alloc_exp_type;
      sel_info_r[alloc_id_o] <= alloc_sel_info;
    end
  end

  assign wb_v_o     = wb_v_r;
  assign wb_type_o  = wb_type_r;
  assign wb_id_o    = wb_id_r;
  assign wb_data_o  = wb_data_r;
  assign err_v_o    = err_v_r;
  assign err_code_o = err_code_r;

endmodule
